// File: rtl/input_capture_pkg.sv
// Shared types and default widths for the processor input-capture block.
package input_capture_pkg;

    localparam int unsigned SW_W_DEF  = 16;
    localparam int unsigned OUT_W_DEF = 32;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_VALID = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/input_capture_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; rise_c is one clk wide.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_c = sync_q & ~prev_q;

endmodule

// File: rtl/input_capture.sv
// One-shot handshaken capture of the switch word on a fresh button press,
// serving the processor's stalling input instruction.
module input_capture
    import input_capture_pkg::*;
#(
    parameter int unsigned SW_W  = SW_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_pulse,
    input  logic [SW_W-1:0]  sw_in,
    input  logic             in_req,
    input  logic             in_ack,
    output logic [OUT_W-1:0] data_out,
    output logic             data_valid,
    output logic             stall,
    output logic             waiting,
    output logic [CNT_W-1:0] dropped_cnt
);

    state_t          state_q;
    state_t          state_next;
    logic            btn_rise_c;
    logic            capture_c;
    logic            drop_c;
    logic [SW_W-1:0] sw_meta;
    logic [SW_W-1:0] sw_s;

    sync_edge u_btn_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (btn_pulse),
        .rise_c (btn_rise_c)
    );

    // Switch word synchronizer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_s    <= sw_meta;
        end
    end

    // Next state; an in_req drop in ARMED wins over a simultaneous press
    always_comb begin
        state_next = state_q;
        capture_c  = 1'b0;
        drop_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                drop_c = btn_rise_c;
                if (in_req) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!in_req) begin
                    state_next = ST_IDLE;
                end else if (btn_rise_c) begin
                    state_next = ST_VALID;
                    capture_c  = 1'b1;
                end
            end
            ST_VALID: begin
                drop_c = btn_rise_c;
                if (in_ack) state_next = ST_DONE;
            end
            ST_DONE: begin
                drop_c = btn_rise_c;
                if (!in_req) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_out    <= '0;
            data_valid  <= 1'b0;
            waiting     <= 1'b0;
            dropped_cnt <= '0;
        end else begin
            state_q    <= state_next;
            data_valid <= (state_next == ST_VALID);
            waiting    <= (state_next == ST_ARMED);
            if (capture_c) data_out <= OUT_W'(sw_s);
            if (drop_c && (dropped_cnt != {CNT_W{1'b1}}))
                dropped_cnt <= dropped_cnt + CNT_W'(1);
        end
    end

    // Combinational so the processor stalls in the same cycle it requests
    assign stall = in_req & ~rst & ((state_q == ST_IDLE) | (state_q == ST_ARMED));

endmodule

// File: tb/tb_input_capture.sv
// Directed self-checking bench for input_capture.
module tb_input_capture;

    logic        clk;
    logic        rst;
    logic        btn_pulse;
    logic [15:0] sw_in;
    logic        in_req;
    logic        in_ack;
    logic [31:0] data_out;
    logic        data_valid;
    logic        stall;
    logic        waiting;
    logic [7:0]  dropped_cnt;

    int total;
    int bad;

    input_capture dut (
        .clk         (clk),
        .rst         (rst),
        .btn_pulse   (btn_pulse),
        .sw_in       (sw_in),
        .in_req      (in_req),
        .in_ack      (in_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .stall       (stall),
        .waiting     (waiting),
        .dropped_cnt (dropped_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h want=%h", data_out, 32'h0); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", data_valid); end
        total++; if (waiting !== 1'b0) begin bad++; $display("FAIL reset_waiting got=%b want=0", waiting); end
        total++; if (dropped_cnt !== 8'd0) begin bad++; $display("FAIL reset_dropped got=%0d want=0", dropped_cnt); end
        tick(2);
        rst = 1'b0;
        tick(2);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b want=0", stall); end
    endtask

    task automatic test_basic();
        sw_in  = 16'hA5C3;
        in_req = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL basic_stall_comb got=%b want=1", stall); end
        tick(1);
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL basic_waiting got=%b want=1", waiting); end
        in_ack = 1'b1;
        tick(1);
        in_ack = 1'b0;
        tick(1);
        total++; if (waiting !== 1'b1 || data_valid !== 1'b0) begin bad++; $display("FAIL basic_ack_ignored got=%b%b want=10", waiting, data_valid); end
        btn_pulse = 1'b1;
        tick(2);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", data_valid); end
        tick(1);
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_latency got=%b want=1", data_valid); end
        total++; if (data_out !== 32'h0000A5C3) begin bad++; $display("FAIL basic_data got=%h want=%h", data_out, 32'h0000A5C3); end
        total++; if (stall !== 1'b0 || waiting !== 1'b0) begin bad++; $display("FAIL basic_stall_wait got=%b%b want=00", stall, waiting); end
        in_req = 1'b0;
        tick(3);
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL basic_req_drop_in_valid got=%b want=1", data_valid); end
        in_req = 1'b1;
        in_ack = 1'b1;
        tick(1);
        in_ack = 1'b0;
        total++; if (data_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL basic_done got=%b%b want=00", data_valid, stall); end
        in_req = 1'b0;
        tick(1);
        in_req = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL basic_back_idle got=%b want=1", stall); end
        in_req = 1'b0;
        tick(295);
        btn_pulse = 1'b0;
        tick(4);
        total++; if (dropped_cnt !== 8'd0) begin bad++; $display("FAIL basic_no_drop got=%0d want=0", dropped_cnt); end
    endtask

    task automatic test_held();
        sw_in  = 16'h1234;
        in_req = 1'b1;
        tick(1);
        btn_pulse = 1'b1;
        tick(3);
        total++; if (data_valid !== 1'b1 || data_out !== 32'h00001234) begin bad++; $display("FAIL held_first got=%b/%h want=1/%h", data_valid, data_out, 32'h00001234); end
        in_ack = 1'b1;
        tick(1);
        in_ack = 1'b0;
        in_req = 1'b0;
        tick(1);
        sw_in  = 16'hFFFF;
        in_req = 1'b1;
        tick(20);
        total++; if (waiting !== 1'b1 || data_valid !== 1'b0 || data_out !== 32'h00001234) begin bad++; $display("FAIL held_second_waits got=%b%b/%h want=10/%h", waiting, data_valid, data_out, 32'h00001234); end
        btn_pulse = 1'b0;
        tick(5);
        btn_pulse = 1'b1;
        tick(3);
        total++; if (data_valid !== 1'b1 || data_out !== 32'h0000FFFF) begin bad++; $display("FAIL held_second got=%b/%h want=1/%h", data_valid, data_out, 32'h0000FFFF); end
        in_ack = 1'b1;
        tick(1);
        in_ack = 1'b0;
        in_req = 1'b0;
        tick(1);
        btn_pulse = 1'b0;
        tick(5);
        total++; if (dropped_cnt !== 8'd0) begin bad++; $display("FAIL held_no_drop got=%0d want=0", dropped_cnt); end
    endtask

    task automatic test_abort();
        sw_in  = 16'h0F0F;
        in_req = 1'b1;
        tick(1);
        total++; if (waiting !== 1'b1) begin bad++; $display("FAIL abort_armed got=%b want=1", waiting); end
        in_req = 1'b0;
        tick(1);
        total++; if (waiting !== 1'b0 || stall !== 1'b0 || data_out !== 32'h0000FFFF) begin bad++; $display("FAIL abort_idle got=%b%b/%h want=00/%h", waiting, stall, data_out, 32'h0000FFFF); end
        btn_pulse = 1'b1;
        tick(5);
        btn_pulse = 1'b0;
        tick(5);
        total++; if (dropped_cnt !== 8'd1 || data_valid !== 1'b0) begin bad++; $display("FAIL abort_drop got=%0d/%b want=1/0", dropped_cnt, data_valid); end
    endtask

    task automatic test_simultaneous();
        in_req = 1'b1;
        tick(1);
        btn_pulse = 1'b1;
        tick(2);
        in_req = 1'b0;
        tick(1);
        total++; if (data_valid !== 1'b0 || waiting !== 1'b0) begin bad++; $display("FAIL simul_state got=%b%b want=00", data_valid, waiting); end
        total++; if (dropped_cnt !== 8'd1 || data_out !== 32'h0000FFFF) begin bad++; $display("FAIL simul_cnt_data got=%0d/%h want=1/%h", dropped_cnt, data_out, 32'h0000FFFF); end
        btn_pulse = 1'b0;
        tick(5);
    endtask

    task automatic test_reset_mid_valid();
        sw_in  = 16'h8001;
        in_req = 1'b1;
        tick(1);
        btn_pulse = 1'b1;
        tick(3);
        total++; if (data_valid !== 1'b1 || data_out !== 32'h00008001) begin bad++; $display("FAIL rstmv_valid got=%b/%h want=1/%h", data_valid, data_out, 32'h00008001); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (data_valid !== 1'b0 || stall !== 1'b0 || waiting !== 1'b0) begin bad++; $display("FAIL rstmv_flags got=%b%b%b want=000", data_valid, stall, waiting); end
        total++; if (data_out !== 32'h0 || dropped_cnt !== 8'd0) begin bad++; $display("FAIL rstmv_regs got=%h/%0d want=0/0", data_out, dropped_cnt); end
        in_req    = 1'b0;
        btn_pulse = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        btn_pulse = 1'b1;
        tick(5);
        btn_pulse = 1'b0;
        tick(5);
        total++; if (dropped_cnt !== 8'd1) begin bad++; $display("FAIL rstmv_drop got=%0d want=1", dropped_cnt); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            btn_pulse = 1'b1;
            tick(4);
            btn_pulse = 1'b0;
            tick(4);
            if (i == 99) begin
                total++; if (dropped_cnt !== 8'd101) begin bad++; $display("FAIL sat_mid got=%0d want=101", dropped_cnt); end
            end
        end
        total++; if (dropped_cnt !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", dropped_cnt); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        btn_pulse = 1'b0;
        sw_in     = 16'h0;
        in_req    = 1'b0;
        in_ack    = 1'b0;
        test_reset();
        test_basic();
        test_held();
        test_abort();
        test_simultaneous();
        test_reset_mid_valid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
